// File: rtl/pool_channel_scheduler.sv
// Round-robin scheduler sharing one 2x2 pooling window controller between
// NUM_CH activation-map channels. It grants one channel, pulses the pooler
// start, counts valid windows, waits for done (or a watchdog abort), then
// acknowledges the channel and moves the round-robin pointer past it.
//
// state  | meaning
// IDLE   | waiting for enable and a request; win_count holds the last pass
// START  | grant/ch_sel driven, pool_start pulsed this cycle
// RUN    | counting pool_valid, watchdog ticking, waiting for pool_done
// FINISH | ch_done pulsed for the owner, count check, pointer advance
module pool_channel_scheduler #(
  parameter  int NUM_CH  = 4,
  parameter  int ACT_W   = 26,
  parameter  int ACT_H   = 26,
  parameter  int POOL_K  = 2,
  parameter  int POOL_S  = 2,
  parameter  int TIMEOUT = 1024,
  localparam int EXP_WIN = ((ACT_W - POOL_K) / POOL_S + 1) * ((ACT_H - POOL_K) / POOL_S + 1),
  localparam int CNT_W   = $clog2(EXP_WIN + 1),
  localparam int CH_W    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   ch_sel,
  output logic              pool_start,
  input  logic              pool_valid,
  input  logic              pool_done,
  output logic [NUM_CH-1:0] ch_done,
  output logic              busy,
  output logic [CNT_W-1:0]  win_count,
  output logic              count_err,
  output logic              timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t           state;
  logic [CH_W-1:0]  rr_ptr;
  logic [WD_W-1:0]  watchdog;
  logic             pick_valid;
  logic [CH_W-1:0]  pick_idx;
  logic [CH_W-1:0]  next_ptr;

  // First requesting channel at or above rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CH;
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = CH_W'(idx);
      end
    end
  end

  // Pointer wrap written explicitly so NUM_CH need not be a power of two.
  assign next_ptr = (ch_sel == CH_W'(NUM_CH - 1)) ? '0 : ch_sel + 1'b1;

  // Moore outputs decoded straight from the state register.
  assign pool_start = (state == START);
  assign ch_done    = (state == FINISH) ? grant : '0;
  assign busy       = (state != IDLE);

  // Sequencer: grant selection, window counting, watchdog and error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      ch_sel      <= '0;
      win_count   <= '0;
      count_err   <= 1'b0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      watchdog    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && pick_valid) begin
            grant     <= NUM_CH'(1) << pick_idx;
            ch_sel    <= pick_idx;
            win_count <= '0;
            watchdog  <= '0;
            state     <= START;
          end
        end
        START: state <= RUN;
        RUN: begin
          // A valid arriving together with done is still counted.
          if (pool_valid && (win_count != '1))
            win_count <= win_count + 1'b1;
          watchdog <= watchdog + 1'b1;
          if (pool_done) begin
            state <= FINISH;
          end else if (watchdog == WD_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= FINISH;
          end
        end
        FINISH: begin
          if (win_count != CNT_W'(EXP_WIN))
            count_err <= 1'b1;
          rr_ptr <= next_ptr;
          grant  <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_channel_scheduler.sv
// Self-checking bench for pool_channel_scheduler: a table of complete passes,
// hand-written corner sequences, then random stimulus against a pass-level model.
module tb_pool_channel_scheduler;

  localparam int NCH      = 4;
  localparam int TMO      = 1024;
  localparam int EXPW     = 169;   // 13 x 13 windows on a 26x26 map
  localparam int CNT_MAX  = 255;   // 8-bit counter saturation

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] grant;
  logic [1:0] ch_sel;
  logic       pool_start;
  logic       pool_valid = 1'b0;
  logic       pool_done = 1'b0;
  logic [3:0] ch_done;
  logic       busy;
  logic [7:0] win_count;
  logic       count_err;
  logic       timeout_err;

  int checks = 0;
  int failures = 0;
  int n_start = 0;
  int n_chdone = 0;

  pool_channel_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .grant(grant), .ch_sel(ch_sel), .pool_start(pool_start),
    .pool_valid(pool_valid), .pool_done(pool_done), .ch_done(ch_done),
    .busy(busy), .win_count(win_count), .count_err(count_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pool_start) n_start++;
    if (|ch_done) n_chdone++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; req = '0; pool_valid = 1'b0; pool_done = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] req;
    int         nvalid;
    bit         merge;      // last valid shares its cycle with pool_done
    logic [3:0] exp_grant;
    logic [1:0] exp_sel;
    int         exp_win;
    bit         exp_cerr;
  } pass_vec_t;

  pass_vec_t tbl[9];

  // Entered at a negedge with the scheduler in IDLE; returns at the negedge
  // of the IDLE cycle that follows FINISH.
  task automatic run_pass(input pass_vec_t v, input int idx);
    string tag;
    tag = $sformatf("pass%0d", idx);
    n_start = 0; n_chdone = 0;
    req = v.req; enable = 1'b1;
    @(negedge clk);
    check({tag, "_grant"}, grant, v.exp_grant);
    check({tag, "_sel"}, ch_sel, v.exp_sel);
    check({tag, "_start"}, pool_start, 1);
    @(negedge clk);
    for (int i = 0; i < v.nvalid; i++) begin
      pool_valid = 1'b1;
      pool_done  = v.merge && (i == v.nvalid - 1);
      @(negedge clk);
      pool_valid = 1'b0; pool_done = 1'b0;
      if (!(v.merge && (i == v.nvalid - 1))) begin
        @(negedge clk); @(negedge clk);
      end
    end
    if (!v.merge) begin
      pool_done = 1'b1;
      @(negedge clk);
      pool_done = 1'b0;
    end
    check({tag, "_chdone"}, ch_done, v.exp_grant);
    check({tag, "_grant_hold"}, grant, v.exp_grant);
    @(negedge clk);
    check({tag, "_idle_gap"}, {busy, grant}, 5'b0);
    check({tag, "_win"}, win_count, v.exp_win);
    check({tag, "_cerr"}, count_err, v.exp_cerr);
    check({tag, "_pulses"}, {n_start[7:0], n_chdone[7:0]}, 16'h0101);
  endtask

  // Pass-level reference model.
  int m_owner, m_stage, m_rc, m_count, m_sel, m_ptr;
  bit m_cerr, m_terr;

  function automatic void model_step();
    if (reset) begin
      m_owner = -1; m_count = 0; m_sel = 0; m_ptr = 0; m_cerr = 0; m_terr = 0;
    end else if (m_owner < 0) begin
      if (enable && req != 0) begin
        for (int i = 0; i < NCH; i++) begin
          int c;
          c = (m_ptr + i) % NCH;
          if (m_owner < 0 && req[c]) m_owner = c;
        end
        m_sel = m_owner; m_count = 0; m_rc = 0; m_stage = 0;
      end
    end else if (m_stage == 0) begin
      m_stage = 1;
    end else if (m_stage == 1) begin
      if (pool_valid && m_count < CNT_MAX) m_count++;
      if (pool_done) m_stage = 2;
      else if (m_rc == TMO - 1) begin m_terr = 1; m_stage = 2; end
      m_rc++;
    end else begin
      if (m_count != EXPW) m_cerr = 1;
      m_ptr = (m_owner + 1) % NCH;
      m_owner = -1;
    end
  endfunction

  function automatic logic [31:0] model_out();
    logic [3:0] g;
    g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    return {10'b0, g, 2'(m_sel), (m_owner >= 0 && m_stage == 0),
            (m_owner >= 0 && m_stage == 2) ? g : 4'b0, (m_owner >= 0),
            8'(m_count), m_cerr, m_terr};
  endfunction

  initial begin
    int k;
    int bad;
    logic [31:0] act;

    tbl[0] = '{4'b0100, 169, 0, 4'b0100, 2'd2, 169, 0};
    tbl[1] = '{4'b1111, 169, 0, 4'b1000, 2'd3, 169, 0};
    tbl[2] = '{4'b1111, 169, 0, 4'b0001, 2'd0, 169, 0};
    tbl[3] = '{4'b1111, 169, 0, 4'b0010, 2'd1, 169, 0};
    tbl[4] = '{4'b1111, 169, 0, 4'b0100, 2'd2, 169, 0};
    tbl[5] = '{4'b1111, 169, 0, 4'b1000, 2'd3, 169, 0};
    tbl[6] = '{4'b1111, 169, 1, 4'b0001, 2'd0, 169, 0};
    tbl[7] = '{4'b0001, 168, 0, 4'b0001, 2'd0, 168, 1};
    tbl[8] = '{4'b1111, 169, 0, 4'b0010, 2'd1, 169, 1};

    @(negedge clk);
    do_reset();
    check("reset_state", {grant, ch_sel, pool_start, ch_done, busy, win_count, count_err, timeout_err},
          22'b0);

    for (int i = 0; i < 9; i++) run_pass(tbl[i], i);

    // enable low blocks grants; raising it grants on the next cycle
    do_reset();
    req = 4'b0001;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant != 0 || pool_start || busy) bad++;
    end
    check("enable_block", bad, 0);
    enable = 1'b1;
    @(negedge clk);
    check("enable_grant", {grant, pool_start}, 5'b00011);
    req = '0;
    @(negedge clk);
    pool_done = 1'b1; @(negedge clk); pool_done = 1'b0;
    @(negedge clk);

    // reset in the middle of a pass
    do_reset();
    req = 4'b0010; enable = 1'b1;
    @(negedge clk);
    check("mid_grant", grant, 4'b0010);
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      pool_valid = 1'b1; @(negedge clk);
    end
    pool_valid = 1'b0;
    check("mid_count50", win_count, 50);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset", {grant, busy, win_count}, 13'b0);
    reset = 1'b0; req = 4'b1000;
    @(negedge clk);
    check("after_reset_grant", {grant, ch_sel, pool_start}, 7'b1000_11_1);
    req = '0;
    @(negedge clk);
    pool_done = 1'b1; @(negedge clk); pool_done = 1'b0;
    @(negedge clk);

    // watchdog abort
    do_reset();
    req = 4'b0001; enable = 1'b1;
    @(negedge clk);
    check("tmo_start", {pool_start, timeout_err}, 2'b10);
    req = '0;
    k = 0;
    while (k < 2000 && ch_done == 0) begin
      @(negedge clk); k++;
    end
    check("tmo_cycles", k, TMO + 1);
    check("tmo_flag", {ch_done, timeout_err}, 5'b0001_1);
    @(negedge clk);
    check("tmo_idle", {busy, timeout_err, count_err}, 3'b011);

    // random stimulus against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset      = (cyc == 0) || ($urandom_range(0, 199) == 0);
      enable     = ($urandom_range(0, 9) != 0);
      req        = 4'($urandom);
      pool_valid = $urandom_range(0, 1) == 1;
      pool_done  = ($urandom_range(0, 15) == 0);
      @(posedge clk);
      model_step();
      @(negedge clk);
      act = {10'b0, grant, ch_sel, pool_start, ch_done, busy, win_count, count_err, timeout_err};
      check("rand_cycle", act, model_out());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
